instr_fetch: RTL

Instruction fetch unit that reads cache lines from the system bus and delivers 32-bit RV64 instruction words in program order to the decode stage (`u_instr`, `uj_instr`, `i_instr`, `r_instr`, `s_instr` and `sb_instr`). It is the producer side of the decoders' `instruction` input. Each 64-bit bus beat carries two instructions, lower word first. One line is buffered at a time, and the unit applies valid/ready backpressure toward decode.

---
 rtl/instr_fetch.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/instr_fetch.sv
// ---------------------------------------------------------------------------
// instr_fetch
//
// Instruction fetch unit. Reads one cache line at a time from the system bus
// into a local line buffer and hands 32-bit instruction words to decode in
// program order with valid/ready backpressure. Each 64-bit beat carries two
// words, the lower word at the lower address.
//
// Parameters
//   BEATS        64-bit beats per line (power of two, 2..16); line = BEATS*8 B
//
// Ports
//   clk, reset   clock; asynchronous active-high reset
//   start        one-cycle pulse, begins fetching at start_pc (IDLE/DONE only)
//   start_pc     first instruction address (4-byte aligned)
//   bus_reqcyc   read request valid         bus_req   line-aligned address
//   bus_reqack   request accepted
//   bus_respcyc  response beat valid        bus_resp  beat data
//   bus_respack  beat accepted (combinational from bus_respcyc while in RESP)
//   instr_valid  instr/instr_pc valid       instr     instruction word
//   instr_pc     address of instr           instr_ready  decode accepts
//   done         fetch halted on a zero word (optional feature)
//
// Build option
//   INSTR_FETCH_HALT_ZERO_EN  when defined, a zero head word stops delivery;
//   the rest of the line is still accepted and discarded, then the unit parks
//   in DONE with done=1 until the next start or reset. When undefined, zero
//   words are ordinary instructions and done is tied low.
// ---------------------------------------------------------------------------
module instr_fetch #(
  parameter int BEATS = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [63:0] start_pc,
  output logic        bus_reqcyc,
  output logic [63:0] bus_req,
  input  logic        bus_reqack,
  input  logic        bus_respcyc,
  input  logic [63:0] bus_resp,
  output logic        bus_respack,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [63:0] instr_pc,
  input  logic        instr_ready,
  output logic        done
);

  localparam int WORDS      = 2 * BEATS;
  localparam int LINE_BYTES = BEATS * 8;
  localparam int WSELW      = $clog2(WORDS);   // word select inside the buffer
  localparam int IDXW       = WSELW + 1;       // head index, can reach WORDS
  localparam int BCW        = $clog2(BEATS) + 1; // beat count, can reach BEATS

  localparam logic [63:0]     LINE_MASK = 64'(LINE_BYTES - 1);
  localparam logic [63:0]     LINE_STEP = 64'(LINE_BYTES);
  localparam logic [IDXW-1:0] IDX_END   = IDXW'(WORDS);
  localparam logic [BCW-1:0]  BEAT_LAST = BCW'(BEATS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_RESP  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [63:0]            line_q, line_d;
  logic [63:0]            pc_q, pc_d;
  logic [BCW-1:0]         beat_q, beat_d;
  logic [WORDS-1:0][31:0] word_q, word_d;

  logic [IDXW-1:0]        head_idx;
  logic [WSELW-1:0]       wr_sel;
  logic [31:0]            head_word;
  logic                   head_written;
  logic                   deliver_ok;
  logic                   zero_head;

  // line_q is always line-aligned, so only the low index bits of pc and line
  // matter; the modular difference is exact because the true offset never
  // exceeds WORDS < 2^IDXW.
  assign head_idx = pc_q[IDXW+1:2] - line_q[IDXW+1:2];

  // Beats land in order, so "head word written" reduces to a compare against
  // twice the number of beats captured so far.
  assign head_written = (head_idx < {beat_q, 1'b0});
  assign head_word    = word_q[head_idx[WSELW-1:0]];
  assign deliver_ok   = ((state_q == S_RESP) || (state_q == S_DRAIN)) && head_written;

`ifdef INSTR_FETCH_HALT_ZERO_EN
  // The head cannot advance past a zero word, so this stays asserted until
  // the unit leaves the line; no separate sticky flag is needed.
  assign zero_head = deliver_ok && (head_word == 32'h0);
  assign done      = (state_q == S_DONE);
`else
  assign zero_head = 1'b0;
  assign done      = 1'b0;
`endif

  assign instr_valid = deliver_ok && !zero_head;
  assign instr       = instr_valid ? head_word : 32'h0;
  assign instr_pc    = instr_valid ? pc_q : 64'h0;

  assign bus_reqcyc  = (state_q == S_REQ);
  assign bus_req     = bus_reqcyc ? line_q : 64'h0;
  assign bus_respack = (state_q == S_RESP) && bus_respcyc;

  // Buffer slot for the low word of the incoming beat. While in RESP the beat
  // count is below BEATS, so its top bit is not needed here.
  assign wr_sel = {beat_q[BCW-2:0], 1'b0};

  always_comb begin
    state_d = state_q;
    line_d  = line_q;
    pc_d    = pc_q;
    beat_d  = beat_q;
    word_d  = word_q;

    // Delivery is independent of the bus side and overlaps RESP and DRAIN.
    if (instr_valid && instr_ready) begin
      pc_d = pc_q + 64'd4;
    end

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          line_d  = start_pc & ~LINE_MASK;
          pc_d    = start_pc;
          beat_d  = '0;
          state_d = S_REQ;
        end
      end

      S_REQ: begin
        if (bus_reqack) begin
          state_d = S_RESP;
        end
      end

      S_RESP: begin
        if (bus_respcyc) begin
          word_d[wr_sel]              = bus_resp[31:0];
          word_d[wr_sel | WSELW'(1)]  = bus_resp[63:32];
          beat_d                      = beat_q + BCW'(1);
          if (beat_q == BEAT_LAST) begin
            state_d = S_DRAIN;
          end
        end
      end

      S_DRAIN: begin
        if (zero_head) begin
          state_d = S_DONE;
        end else if (head_idx == IDX_END) begin
          // pc already sits on the next line's first word.
          line_d  = line_q + LINE_STEP;
          beat_d  = '0;
          state_d = S_REQ;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      line_q  <= 64'h0;
      pc_q    <= 64'h0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      line_q  <= line_d;
      pc_q    <= pc_d;
      beat_q  <= beat_d;
    end
  end

  // Line data needs no reset: a word is only read once the beat count says
  // it has been written, and the outputs are gated by instr_valid.
  always_ff @(posedge clk) begin
    word_q <= word_d;
  end

endmodule
